// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM receive demultiplexer: FSM encoding and
// a counter-width helper.
package tdm_demux_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_e;

  // Bits needed to count 0..v-1, never less than one so counters stay legal.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tdm_demux_sipo_shift.sv
// W-bit serial-in/parallel-out shift register; new bits enter at the LSB so
// the first bit received ends up as the MSB of a full word.
module sipo_shift #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         sin_i,
  output logic [W-1:0] par_o
);

  logic [W-1:0] shift_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      shift_q <= '0;
    end else if (en_i) begin
      shift_q <= {shift_q[W-2:0], sin_i};
    end
  end

  assign par_o = shift_q;

endmodule

// File: rtl/tdm_demux.sv
// Receive side of the TDM serial link: locks to the frame marker, deserializes
// W-bit words and steers them to N channels, plus an atomic whole-frame update.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sin,
  input  logic           sin_en,
  input  logic           sync,
  output logic [W-1:0]   ch_data,
  output logic [N-1:0]   ch_valid,
  output logic [N*W-1:0] frame_data,
  output logic           frame_valid,
  output logic           locked,
  output logic           sync_err
);

  localparam int BW = clog2_min1(W);
  localparam int CW = clog2_min1(N);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(N - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [N-1:0]  ONEHOT0  = N'(1);

  // Handshake: sin/sync are consumed only on cycles with sin_en high; every
  // *_valid / sync_err output is a single-cycle pulse with no back-pressure.

  state_e         state_q;
  logic [BW-1:0]  bit_cnt_q;
  logic [CW-1:0]  ch_cnt_q;
  logic [W-1:0]   stage_q [N];
  logic [W-1:0]   ch_data_q;
  logic [N-1:0]   ch_valid_q;
  logic [N*W-1:0] frame_data_q;
  logic           frame_valid_q;
  logic           locked_q;
  logic           sync_err_q;

  logic [W-1:0]   shift_q;
  logic [W-1:0]   word_d;
  logic [N*W-1:0] frame_d;
  logic [N-1:0]   ch_onehot_d;
  logic           frame_pos0;
  logic           unused_oldest_bit;

  sipo_shift #(.W(W)) u_sipo (
    .clk_i (clk),
    .clr_i (rst),
    .en_i  (sin_en),
    .sin_i (sin),
    .par_o (shift_q)
  );

  // The completing word includes the bit being sampled this cycle; the oldest
  // register bit drops out as that bit arrives.
  assign word_d            = {shift_q[W-2:0], sin};
  assign unused_oldest_bit = shift_q[W-1];
  assign frame_pos0        = (bit_cnt_q == '0) && (ch_cnt_q == '0);
  assign ch_onehot_d       = ONEHOT0 << ch_cnt_q;

  always_comb begin
    frame_d = '0;
    for (int k = 0; k < N; k++) begin
      frame_d[k*W +: W] = (k == N - 1) ? word_d : stage_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      bit_cnt_q     <= '0;
      ch_cnt_q      <= '0;
      for (int k = 0; k < N; k++) begin
        stage_q[k] <= '0;
      end
      ch_data_q     <= '0;
      ch_valid_q    <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      ch_valid_q    <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      if (sin_en) begin
        case (state_q)
          HUNT: begin
            if (sync) begin
              state_q   <= RECV;
              locked_q  <= 1'b1;
              bit_cnt_q <= BIT_ONE;
              ch_cnt_q  <= '0;
            end
          end
          RECV: begin
            if (frame_pos0 && !sync) begin
              // Lost frame alignment: drop the bit and hunt for the marker.
              sync_err_q <= 1'b1;
              state_q    <= HUNT;
              locked_q   <= 1'b0;
              bit_cnt_q  <= '0;
              ch_cnt_q   <= '0;
            end else if (!frame_pos0 && sync) begin
              // Marker arrived early: abandon the partial frame and restart on it.
              sync_err_q <= 1'b1;
              bit_cnt_q  <= BIT_ONE;
              ch_cnt_q   <= '0;
            end else if (bit_cnt_q == BIT_LAST) begin
              ch_data_q         <= word_d;
              ch_valid_q        <= ch_onehot_d;
              stage_q[ch_cnt_q] <= word_d;
              bit_cnt_q         <= '0;
              if (ch_cnt_q == CH_LAST) begin
                frame_data_q  <= frame_d;
                frame_valid_q <= 1'b1;
                ch_cnt_q      <= '0;
              end else begin
                ch_cnt_q <= ch_cnt_q + CW'(1);
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_ONE;
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ch_data     = ch_data_q;
  assign ch_valid    = ch_valid_q;
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: a frame-position model predicts every output
// each cycle, and literal expectations pin the model on the key scenarios.
module tb_tdm_demux;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           sin;
  logic           sin_en;
  logic           sync;
  logic [W-1:0]   ch_data;
  logic [N-1:0]   ch_valid;
  logic [N*W-1:0] frame_data;
  logic           frame_valid;
  logic           locked;
  logic           sync_err;

  tdm_demux #(.N(N), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .sin         (sin),
    .sin_en      (sin_en),
    .sync        (sync),
    .ch_data     (ch_data),
    .ch_valid    (ch_valid),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fv_cnt   = 0;
  int se_cnt   = 0;
  logic [N+W-1:0] got_q[$];
  int             fv_cyc_q[$];

  // ---------------- behavioural model ----------------
  // Tracks the absolute bit position inside the frame and accumulates each
  // word arithmetically; expected outputs are what must be visible after the edge.
  bit             m_locked;
  int             m_pos;
  int             m_acc;
  logic [W-1:0]   m_words [N];
  logic [W-1:0]   e_ch_data;
  logic [N-1:0]   e_ch_valid;
  logic [N*W-1:0] e_frame_data;
  logic           e_frame_valid;
  logic           e_locked;
  logic           e_sync_err;

  task automatic model_step(input logic r, input logic en, input logic s, input logic sy);
    int ch;
    e_ch_valid    = '0;
    e_frame_valid = 1'b0;
    e_sync_err    = 1'b0;
    if (r) begin
      m_locked     = 1'b0;
      m_pos        = 0;
      m_acc        = 0;
      e_ch_data    = '0;
      e_frame_data = '0;
      for (int k = 0; k < N; k++) m_words[k] = '0;
    end else if (en) begin
      if (!m_locked) begin
        if (sy) begin
          m_locked = 1'b1;
          m_pos    = 1;
          m_acc    = int'(s);
        end
      end else if (m_pos == 0 && !sy) begin
        e_sync_err = 1'b1;
        m_locked   = 1'b0;
      end else if (m_pos != 0 && sy) begin
        e_sync_err = 1'b1;
        m_pos      = 1;
        m_acc      = int'(s);
      end else begin
        m_acc = (m_pos % W == 0) ? int'(s) : m_acc * 2 + int'(s);
        m_pos = m_pos + 1;
        if (m_pos % W == 0) begin
          ch          = m_pos / W - 1;
          e_ch_data   = W'(m_acc);
          e_ch_valid  = N'(1) << ch;
          m_words[ch] = W'(m_acc);
          if (ch == N - 1) begin
            for (int k = 0; k < N; k++) e_frame_data[k*W +: W] = m_words[k];
            e_frame_valid = 1'b1;
            m_pos         = 0;
          end
        end
      end
    end
    e_locked = m_locked;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic compare_all();
    chk("ch_data",     64'(ch_data),     64'(e_ch_data));
    chk("ch_valid",    64'(ch_valid),    64'(e_ch_valid));
    chk("frame_data",  64'(frame_data),  64'(e_frame_data));
    chk("frame_valid", 64'(frame_valid), 64'(e_frame_valid));
    chk("locked",      64'(locked),      64'(e_locked));
    chk("sync_err",    64'(sync_err),    64'(e_sync_err));
  endtask

  task automatic clear_tally();
    fv_cnt = 0;
    se_cnt = 0;
    got_q.delete();
    fv_cyc_q.delete();
  endtask

  // ---------------- drivers ----------------
  // Inputs change 1 time unit after the active edge; outputs are checked there too.
  task automatic step(input logic r, input logic en, input logic s, input logic sy);
    rst    = r;
    sin_en = en;
    sin    = s;
    sync   = sy;
    model_step(r, en, s, sy);
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
    if (ch_valid !== '0) got_q.push_back({ch_valid, ch_data});
    if (frame_valid === 1'b1) begin
      fv_cnt++;
      fv_cyc_q.push_back(cyc);
    end
    if (sync_err === 1'b1) se_cnt++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Sends frame bits [from, to) MSB-first per channel; marker on bit 0 if first_sync.
  task automatic send_range(input logic [N*W-1:0] f, input int from, input int to,
                            input bit first_sync, input int max_gap);
    logic [W-1:0] wd;
    for (int b = from; b < to; b++) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      wd = f[(b / W) * W +: W];
      step(1'b0, 1'b1, wd[W - 1 - (b % W)], (b == 0) && first_sync);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [N*W-1:0] f_a, f_b, f_c, f_d, f_e;
  logic [N+W-1:0] exp_a [N];

  initial begin
    f_a = 32'h01FF3CA5;
    f_b = 32'h5A6B7C8D;
    f_c = 32'h12345678;
    f_d = 32'hC0FFEE00;
    f_e = 32'hDEADBEEF;
    exp_a[0] = 12'h1A5;
    exp_a[1] = 12'h23C;
    exp_a[2] = 12'h4FF;
    exp_a[3] = 12'h801;
    rst = 1'b0; sin = 1'b0; sin_en = 1'b0; sync = 1'b0;

    // Reset then lock
    do_reset(2);
    chk("rst_ch_data",    64'(ch_data),    64'h0);
    chk("rst_frame_data", 64'(frame_data), 64'h0);
    chk("rst_locked",     64'(locked),     64'h0);
    clear_tally();
    send_range(f_a, 0, 1, 1'b1, 0);
    chk("lock_after_first_bit", 64'(locked), 64'h1);
    send_range(f_a, 1, N * W, 1'b1, 0);
    chk("t1_words_n", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < N && i < got_q.size(); i++) chk("t1_word", 64'(got_q[i]), 64'(exp_a[i]));
    chk("t1_frame_data", 64'(frame_data), 64'h01FF3CA5);
    chk("t1_fv_cnt",     64'(fv_cnt),     64'd1);

    // Gapped strobes
    idle(3);
    clear_tally();
    send_range(f_a, 0, N * W, 1'b1, 3);
    idle(2);
    chk("t2_words_n", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < N && i < got_q.size(); i++) chk("t2_word", 64'(got_q[i]), 64'(exp_a[i]));
    chk("t2_frame_data", 64'(frame_data), 64'h01FF3CA5);
    chk("t2_fv_cnt",     64'(fv_cnt),     64'd1);
    chk("t2_se_cnt",     64'(se_cnt),     64'd0);

    // Early sync at bit 3 of channel 2
    clear_tally();
    send_range(f_a, 0, 2 * W + 3, 1'b1, 0);
    chk("t3_fv_before", 64'(fv_cnt), 64'd0);
    send_range(f_b, 0, N * W, 1'b1, 0);
    chk("t3_se_cnt",     64'(se_cnt),     64'd1);
    chk("t3_fv_cnt",     64'(fv_cnt),     64'd1);
    chk("t3_words_n",    64'(got_q.size()), 64'd6);
    if (got_q.size() > 2) chk("t3_new_ch0", 64'(got_q[2]), 64'h18D);
    chk("t3_frame_data", 64'(frame_data), 64'h5A6B7C8D);

    // Missing sync on frame 2
    clear_tally();
    send_range(f_c, 0, N * W, 1'b1, 0);
    send_range(f_d, 0, 1, 1'b0, 0);
    chk("t4_sync_err", 64'(sync_err), 64'h1);
    chk("t4_unlocked", 64'(locked),   64'h0);
    send_range(f_d, 1, N * W, 1'b0, 0);
    chk("t4_hold_frame", 64'(frame_data), 64'h12345678);
    send_range(f_e, 0, N * W, 1'b1, 0);
    chk("t4_se_cnt",     64'(se_cnt),       64'd1);
    chk("t4_fv_cnt",     64'(fv_cnt),       64'd2);
    chk("t4_words_n",    64'(got_q.size()), 64'd8);
    chk("t4_frame_data", 64'(frame_data),   64'hDEADBEEF);

    // Reset mid-frame after channel 1 completes
    clear_tally();
    send_range(f_a, 0, 2 * W, 1'b1, 0);
    do_reset(1);
    chk("t5_ch_data",    64'(ch_data),    64'h0);
    chk("t5_frame_data", 64'(frame_data), 64'h0);
    chk("t5_locked",     64'(locked),     64'h0);
    clear_tally();
    send_range(f_c, 0, N * W, 1'b0, 0);
    chk("t5_ignored_words", 64'(got_q.size()), 64'd0);
    chk("t5_still_hunt",    64'(locked),       64'h0);
    send_range(f_b, 0, N * W, 1'b1, 0);
    chk("t5_frame_data", 64'(frame_data), 64'h5A6B7C8D);

    // Back-to-back frames
    clear_tally();
    send_range(f_a, 0, N * W, 1'b1, 0);
    send_range(f_b, 0, N * W, 1'b1, 0);
    send_range(f_c, 0, N * W, 1'b1, 0);
    idle(2);
    chk("t6_fv_cnt", 64'(fv_cnt), 64'd3);
    chk("t6_se_cnt", 64'(se_cnt), 64'd0);
    for (int i = 1; i < fv_cyc_q.size(); i++)
      chk("t6_fv_spacing", 64'(fv_cyc_q[i] - fv_cyc_q[i-1]), 64'd32);
    chk("t6_frame_data", 64'(frame_data), 64'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive end of a time-division-multiplexed serial link: a serial bit stream carrying N channels of W-bit words, one frame at a time.
- Frame-locks on a sync marker and steers each deserialized word to its own channel (1-to-N demultiplexing).
- Presents the per-channel word as it completes, plus the whole frame as one atomic update.
- Sits downstream of the mux-based TDM transmitter in the lab datapath.

Parameters:
- N, 4, number of channels per frame (>=2)
- W, 8, bits per channel word (>=2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- sin  input  1  serial data bit, MSB of each word first
- sin_en  input  1  bit strobe; sin/sync sampled only when high
- sync  input  1  frame marker; high with bit 0 of channel 0
- ch_data  output  W  most recently completed channel word
- ch_valid  output  N  one-hot, 1-cycle pulse naming the channel of ch_data
- frame_data  output  N*W  complete frame; channel k at bits [k*W +: W]
- frame_valid  output  1  1-cycle pulse when frame_data updates
- locked  output  1  high while in RECV
- sync_err  output  1  1-cycle pulse on a framing violation

Behaviour:
- Reset (rst high at a clk edge): state HUNT; bit_cnt, ch_cnt, shift register and staging cleared; every output 0.
  - Reset mid-frame discards all partial data.
- Cycles with sin_en low change nothing; all pulse outputs return to 0.
- HUNT:
  - Bits are discarded until a strobed bit arrives with sync=1.
  - That bit is bit 0 of channel 0. Go to RECV with bit_cnt=1, ch_cnt=0.
- RECV, on each strobed bit:
  - shift = {shift[W-2:0], sin}.
  - If bit_cnt==W-1, the word completes.
    - Next edge: ch_data <= the word; ch_valid <= one-hot(ch_cnt); staging[ch_cnt] <= the word.
    - bit_cnt wraps to 0; ch_cnt increments.
  - On completion of channel N-1:
    - frame_data <= all staged words plus the new word, in the same edge as the final ch_valid.
    - frame_valid pulses.
    - ch_cnt wraps to 0; state stays RECV.
- Latency: outputs appear in the cycle after the clk edge that samples the last bit. No other latency. Back-to-back strobes every cycle are supported.
- Framing checks (RECV only):
  - sync=1 on a bit that is not frame position 0:
    - sync_err pulses.
    - Partial frame dropped; no ch_valid for the partial word, no frame_valid.
    - The bit is taken as bit 0 of a new frame (bit_cnt=1, ch_cnt=0). Stay RECV.
  - sync=0 on a bit at frame position 0 (expected start):
    - sync_err pulses.
    - Go to HUNT; the bit is discarded.
  - Completed words of channels before the error remain on ch_data; frame_data keeps the last good frame.
- locked = (state==RECV), registered.
- Counters: bit_cnt is clog2(W) bits and ch_cnt is clog2(N) bits. Both wrap explicitly at W-1 / N-1, not on overflow.

Decomposition:
- Shared package/include: state encodings (HUNT=0, RECV=1) and a clog2 helper constant function.
- One natural sub-module: sipo_shift, a W-bit serial-in/parallel-out shift register with enable and synchronous clear.
  - Instantiated once.
  - The demux FSM, counters and staging stay in tdm_demux.

Test Plan:
- Reset then lock (N=4, W=8):
  - Stimulus: rst 2 cycles, then a continuous frame 0xA5, 0x3C, 0xFF, 0x01 with sync on the first bit.
  - Required: ch_valid 0001, 0010, 0100, 1000 with the matching ch_data; frame_data=0x01FF3CA5; frame_valid one pulse; locked=1 from the cycle after the first bit.
- Gapped strobes:
  - Stimulus: the same frame with sin_en low on random cycles.
  - Required: identical outputs, with each pulse delayed only by the gaps; no output change during gaps.
- Early sync:
  - Stimulus: sync=1 at bit 3 of channel 2.
  - Required: sync_err one pulse; no ch_valid for channel 2; no frame_valid. The following 32 bits are received as a full frame: frame_valid fires with the new words.
- Missing sync:
  - Stimulus: frame 2 starts with sync=0.
  - Required: sync_err one pulse; locked falls; no outputs until the next sync=1 bit, after which the next frame is received correctly.
- Reset mid-frame:
  - Stimulus: rst high after channel 1 completes.
  - Required: all outputs 0; state HUNT; bits before a new sync ignored.
- Back-to-back frames:
  - Stimulus: 3 frames with sin_en held high.
  - Required: frame_valid exactly every 32 cycles; sync_err never asserted.
